counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
Control end of the calendar counter bank. Turns a 1 Hz tick into `inc` pulses and ripples carries by watching `done_inc`. Handles manual field editing with up/down buttons, and drives the `day_num`/`hour_num` limits, including leap years. Re-clamps `day`/`hour` with `dec` pulses after any month, year or 12/24h change, so no count sits above its limit.

Parameters:
- YEAR_BASE_LEAP, 0, year count value that is a leap year (year 0 = 2000); leap when (year-YEAR_BASE_LEAP)%4==0, except year==100.
- NUM_FIELDS, 6, number of counter fields: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle pulse per second
- mode_set  in  1  1 = edit mode, time frozen
- field_sel  in  3  field to edit, 0..5; 6/7 select nothing
- btn_up  in  1  debounced one-cycle pulse
- btn_down  in  1  debounced one-cycle pulse
- hour_24  in  1  1 = 24 h (hour max 23), 0 = 12 h (hour max 11)
- hour  in  5  current hour count
- day  in  5  current day count
- month  in  4  current month count
- year  in  7  current year count
- done_inc  in  5  per-field wrap on inc, fields 0..4; high in the same cycle as the wrapping `inc`
- done_dec  in  5  per-field wrap on dec, fields 0..4; informational only
- inc  out  6  one-cycle increment request per field
- dec  out  6  one-cycle decrement request per field
- en  out  6  per-field count enable
- day_num  out  5  days in current month
- hour_num  out  5  hour maximum
- busy  out  1  carry or clamp sequence in progress

Behaviour:
- Reset values: inc=0, dec=0, en=6'h3F, hour_num=23, busy=0, state IDLE, tick_pend=0.
- `day_num` is combinational from month/year:
  - 31,28,31,30,31,30,31,31,30,31,30,31 for months 1..12.
  - Feb = 29 if leap.
  - month 0 or 13..15 gives 31.
- `hour_num` is registered: 23 if hour_24 else 11. A change in hour_24 sets a clamp request.
- `en` is registered:
  - run mode: 6'h3F.
  - edit mode: one-hot of field_sel, or 0 for 6/7.
  - CLAMP: one-hot of the field being decremented.
- `inc`/`dec` are registered one-cycle pulses, never both set, at most one bit set.
- FSM states: IDLE, CARRY(k), CLAMP_CHK, CLAMP_WAIT.
- IDLE, run mode, tick_1hz (or tick_pend) → pulse inc[0], k=0, go CARRY, busy=1.
- CARRY(k):
  - Sample done_inc[k] in the cycle inc[k] is high.
  - If set and k<5: pulse inc[k+1] next cycle, k=k+1.
  - Otherwise go CLAMP_CHK.
  - Full rollover (23:59:59, Dec 31) gives inc[0..5] on cycles t..t+5, and busy clears at t+7.
- IDLE, edit mode, btn_up (or btn_down) with a valid field_sel:
  - Pulse inc[f] (or dec[f]) once; done_* ignored, no carry.
  - If f is 4 or 5, go CLAMP_CHK; otherwise stay IDLE.
  - btn_up and btn_down together: both ignored.
- Clamp request (hour_24 change) in IDLE → CLAMP_CHK.
- CLAMP_CHK:
  - If hour > hour_num: pulse dec[2] → CLAMP_WAIT.
  - Else if day > day_num: pulse dec[3] → CLAMP_WAIT.
  - Else → IDLE, busy=0.
- CLAMP_WAIT: one cycle for the counter to update, then → CLAMP_CHK. Decrement pulses are therefore spaced 2 cycles apart.
- Ticks while busy set tick_pend (one deep; further ticks dropped). tick_pend is cleared when serviced.
- Ticks in edit mode are discarded. Buttons while busy are dropped.
- mode_set changing mid-sequence: the sequence completes first; en updates on return to IDLE.
- Reset mid-sequence: all outputs return to reset values immediately; no residual pulses.

Decomposition:
- Package counter_ctrl_pkg:
  - field index constants (F_SEC..F_YEAR)
  - HOUR_MAX_24=23, HOUR_MAX_12=11
  - DAYS_IN_MONTH constant array
  - FSM state enum
- Sub-module days_in_month: combinational month/year → day_num lookup including the leap rule.

Test Plan:
1. Reset asserted → inc=0, dec=0, en=6'h3F, hour_num=23, busy=0; hold 5 cycles, no pulses.
2. Counter stub at 23:59:59, Dec 31, year 5; tick at t → inc[0..5] at t..t+5, each with done_inc echoed, busy low at t+7. A non-wrapping tick → only inc[0], busy low at t+2.
3. day_num lookup:
   - month=2, year=24 → 29
   - month=2, year=25 → 28
   - month=2, year=100 → 28
   - month=4 → 30
   - month=0 → 31
4. Edit mode, field_sel=4, day=31, month=1, year=25; btn_up → inc[4] with en=6'b010000. Stub month becomes 2 → three dec[3] pulses 2 cycles apart with en=6'b001000; day ends 28; busy drops.
5. hour=17, hour_24 1→0 → hour_num=11, six dec[2] pulses, hour ends 11. Toggle back 0→1 → hour_num=23, no pulses.
6. Two ticks during a carry chain → exactly one extra inc[0] after busy clears. Reset_n low mid-chain → inc=0 and en=6'h3F in the same cycle; no pulse after release without a new tick.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the calendar counter controller: field indices,
// hour limits, the month length table and the sequencer state encoding.
package counter_ctrl_pkg;

    // Field indices into the inc/dec/en vectors.
    localparam int unsigned F_SEC   = 0;
    localparam int unsigned F_MIN   = 1;
    localparam int unsigned F_HOUR  = 2;
    localparam int unsigned F_DAY   = 3;
    localparam int unsigned F_MONTH = 4;
    localparam int unsigned F_YEAR  = 5;

    // Highest hour count in each display mode.
    localparam logic [4:0] HOUR_MAX_24 = 5'd23;
    localparam logic [4:0] HOUR_MAX_12 = 5'd11;

    // Year count that breaks the four-year leap cycle (2100).
    localparam logic [6:0] YEAR_NO_LEAP = 7'd100;

    // Days per month indexed by month count; out-of-range months read as 31.
    localparam logic [4:0] DAYS_IN_MONTH [16] = '{
        5'd31,                                   // 0 (invalid)
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30, // Jan..Jun
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31, // Jul..Dec
        5'd31, 5'd31, 5'd31                       // 13..15 (invalid)
    };

    typedef enum logic [1:0] {
        StIdle,
        StCarry,
        StClampChk,
        StClampWait
    } state_e;

endpackage

// File: rtl/days_in_month.sv
// Month/year to month-length lookup, including the leap-year rule.
module days_in_month
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned YEAR_BASE_LEAP = 0
) (
    input  logic [3:0] month_i,
    input  logic [6:0] year_i,
    output logic [4:0] day_num_o
);

    logic [1:0] year_rel_lo;
    logic       leap;

    // Table lookup, then patch February in leap years.
    always_comb begin
        // Only the low two bits matter for the mod-4 test.
        year_rel_lo = 2'(year_i - 7'(YEAR_BASE_LEAP));
        leap        = (year_rel_lo == 2'b00) && (year_i != YEAR_NO_LEAP);
        day_num_o   = DAYS_IN_MONTH[month_i];
        if ((month_i == 4'd2) && leap) begin
            day_num_o = 5'd29;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for the calendar counter bank: second ticks become carry chains,
// button presses become single-field edits, and limit changes trigger a
// clamp sequence that walks hour/day back under their maxima.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned YEAR_BASE_LEAP = 0,
    parameter int unsigned NUM_FIELDS     = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick_1hz,
    input  logic                  mode_set,
    input  logic [2:0]            field_sel,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  hour_24,
    input  logic [4:0]            hour,
    input  logic [4:0]            day,
    input  logic [3:0]            month,
    input  logic [6:0]            year,
    input  logic [NUM_FIELDS-2:0] done_inc,
    input  logic [NUM_FIELDS-2:0] done_dec,
    output logic [NUM_FIELDS-1:0] inc,
    output logic [NUM_FIELDS-1:0] dec,
    output logic [NUM_FIELDS-1:0] en,
    output logic [4:0]            day_num,
    output logic [4:0]            hour_num,
    output logic                  busy
);

    localparam logic [2:0] CarryLast = 3'(NUM_FIELDS - 1);

    state_e                state_q, state_d;
    logic [2:0]            carry_q, carry_d;
    logic [NUM_FIELDS-1:0] inc_q, inc_d;
    logic [NUM_FIELDS-1:0] dec_q, dec_d;
    logic [NUM_FIELDS-1:0] en_q, en_d;
    logic                  tick_pend_q, tick_pend_d;
    logic                  clamp_pend_q, clamp_pend_d;
    logic                  hour_24_q;
    logic [4:0]            hour_num_q;
    logic                  busy_q;

    logic [7:0]            done_ext;
    logic [NUM_FIELDS-1:0] sel_oh;
    logic [NUM_FIELDS-1:0] mode_en;
    logic                  sel_valid;
    logic                  hour_24_chg;
    logic                  tick_run;
    logic                  btn_one;
    logic                  unused_done_dec;

    days_in_month #(
        .YEAR_BASE_LEAP(YEAR_BASE_LEAP)
    ) u_days_in_month (
        .month_i  (month),
        .year_i   (year),
        .day_num_o(day_num)
    );

    // Wraps on decrement carry no information for sequencing.
    assign unused_done_dec = ^done_dec;

    // Zero-extended so any carry index can address it safely.
    assign done_ext    = 8'(done_inc);
    assign hour_24_chg = hour_24 ^ hour_24_q;
    assign tick_run    = tick_1hz & ~mode_set;
    assign btn_one     = btn_up ^ btn_down;

    // Decode the edit field and the enable pattern for the current mode.
    always_comb begin
        sel_oh    = '0;
        sel_valid = 32'(field_sel) < NUM_FIELDS;
        if (sel_valid) begin
            sel_oh[field_sel] = 1'b1;
        end
        mode_en = mode_set ? sel_oh : '1;
    end

    // Next-state and pulse generation for the carry/edit/clamp sequencer.
    always_comb begin
        state_d      = state_q;
        carry_d      = carry_q;
        inc_d        = '0;
        dec_d        = '0;
        en_d         = en_q;
        tick_pend_d  = tick_pend_q | tick_run;
        clamp_pend_d = clamp_pend_q | hour_24_chg;

        unique case (state_q)
            StIdle: begin
                en_d        = mode_en;
                // Pending ticks are serviced here or dropped in edit mode.
                tick_pend_d = 1'b0;
                if (clamp_pend_q) begin
                    clamp_pend_d = hour_24_chg;
                    tick_pend_d  = (tick_run | tick_pend_q) & ~mode_set;
                    state_d      = StClampChk;
                end else if (!mode_set && (tick_1hz || tick_pend_q)) begin
                    inc_d[F_SEC] = 1'b1;
                    carry_d      = '0;
                    state_d      = StCarry;
                end else if (mode_set && btn_one && sel_valid) begin
                    if (btn_up) begin
                        inc_d = sel_oh;
                    end else begin
                        dec_d = sel_oh;
                    end
                    // Month/year edits can shrink the day limit.
                    if ((field_sel == 3'(F_MONTH)) || (field_sel == 3'(F_YEAR))) begin
                        state_d = StClampChk;
                    end
                end
            end

            StCarry: begin
                // inc[carry_q] is high this cycle, so done_inc is valid for it.
                if ((carry_q < CarryLast) && done_ext[carry_q]) begin
                    carry_d        = carry_q + 3'd1;
                    inc_d[carry_d] = 1'b1;
                end else begin
                    state_d = StClampChk;
                end
            end

            StClampChk: begin
                if ((inc_q != '0) || (dec_q != '0)) begin
                    // An edit pulse is still landing; compare next cycle.
                    state_d = StClampChk;
                end else if (hour > hour_num_q) begin
                    dec_d[F_HOUR] = 1'b1;
                    en_d          = '0;
                    en_d[F_HOUR]  = 1'b1;
                    state_d       = StClampWait;
                end else if (day > day_num) begin
                    dec_d[F_DAY] = 1'b1;
                    en_d         = '0;
                    en_d[F_DAY]  = 1'b1;
                    state_d      = StClampWait;
                end else begin
                    en_d    = mode_en;
                    state_d = StIdle;
                end
            end

            StClampWait: begin
                state_d = StClampChk;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            carry_q      <= '0;
            inc_q        <= '0;
            dec_q        <= '0;
            en_q         <= '1;
            tick_pend_q  <= 1'b0;
            clamp_pend_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            carry_q      <= carry_d;
            inc_q        <= inc_d;
            dec_q        <= dec_d;
            en_q         <= en_d;
            tick_pend_q  <= tick_pend_d;
            clamp_pend_q <= clamp_pend_d;
            busy_q       <= (state_d != StIdle);
        end
    end

    // Hour limit tracks the 12/24 h select one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hour_24_q  <= 1'b1;
            hour_num_q <= HOUR_MAX_24;
        end else begin
            hour_24_q  <= hour_24;
            hour_num_q <= hour_24 ? HOUR_MAX_24 : HOUR_MAX_12;
        end
    end

    assign inc      = inc_q;
    assign dec      = dec_q;
    assign en       = en_q;
    assign hour_num = hour_num_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: a behavioural counter-bank stub closes the loop,
// expected pulses are queued at stimulus time and matched against pulses
// captured by a monitor.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick_1hz;
    logic       mode_set;
    logic [2:0] field_sel;
    logic       btn_up;
    logic       btn_down;
    logic       hour_24;
    logic [4:0] hour;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [4:0] done_inc;
    logic [4:0] done_dec;
    logic [5:0] inc;
    logic [5:0] dec;
    logic [5:0] en;
    logic [4:0] day_num;
    logic [4:0] hour_num;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int obs_rd = 0;

    typedef struct {
        int         cyc;
        logic [5:0] inc;
        logic [5:0] dec;
        logic [5:0] en;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t obs_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    counter_ctrl u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick_1hz (tick_1hz),
        .mode_set (mode_set),
        .field_sel(field_sel),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .hour_24  (hour_24),
        .hour     (hour),
        .day      (day),
        .month    (month),
        .year     (year),
        .done_inc (done_inc),
        .done_dec (done_dec),
        .inc      (inc),
        .dec      (dec),
        .en       (en),
        .day_num  (day_num),
        .hour_num (hour_num),
        .busy     (busy)
    );

    // Independent month-length model for the stub.
    function automatic int tb_days(input int m, input int y);
        case (m)
            4, 6, 9, 11: return 30;
            2:           return (((y % 4) == 0) && (y != 100)) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    // Counter-bank stub.
    logic [5:0] s_sec, s_min;
    logic [4:0] s_hour, s_day;
    logic [3:0] s_month;
    logic [6:0] s_year;
    logic       ld = 1'b0;
    logic [5:0] ld_sec, ld_min;
    logic [4:0] ld_hour, ld_day;
    logic [3:0] ld_month;
    logic [6:0] ld_year;
    int         hmax;
    int         dmax;

    assign hour  = s_hour;
    assign day   = s_day;
    assign month = s_month;
    assign year  = s_year;
    assign hmax  = hour_24 ? 23 : 11;
    assign dmax  = tb_days(int'(s_month), int'(s_year));

    assign done_inc[0] = inc[0] && (s_sec == 6'd59);
    assign done_inc[1] = inc[1] && (s_min == 6'd59);
    assign done_inc[2] = inc[2] && (int'(s_hour) == hmax);
    assign done_inc[3] = inc[3] && (int'(s_day) == dmax);
    assign done_inc[4] = inc[4] && (s_month == 4'd12);
    assign done_dec[0] = dec[0] && (s_sec == 6'd0);
    assign done_dec[1] = dec[1] && (s_min == 6'd0);
    assign done_dec[2] = dec[2] && (s_hour == 5'd0);
    assign done_dec[3] = dec[3] && (s_day == 5'd1);
    assign done_dec[4] = dec[4] && (s_month == 4'd1);

    always @(posedge clk) begin
        if (ld) begin
            s_sec <= ld_sec; s_min <= ld_min; s_hour <= ld_hour;
            s_day <= ld_day; s_month <= ld_month; s_year <= ld_year;
        end else begin
            if (inc[0]) s_sec <= (s_sec == 6'd59) ? 6'd0 : s_sec + 6'd1;
            if (inc[1]) s_min <= (s_min == 6'd59) ? 6'd0 : s_min + 6'd1;
            if (inc[2]) s_hour <= (int'(s_hour) == hmax) ? 5'd0 : s_hour + 5'd1;
            if (inc[3]) s_day <= (int'(s_day) == dmax) ? 5'd1 : s_day + 5'd1;
            if (inc[4]) s_month <= (s_month == 4'd12) ? 4'd1 : s_month + 4'd1;
            if (inc[5]) s_year <= s_year + 7'd1;
            if (dec[0]) s_sec <= (s_sec == 6'd0) ? 6'd59 : s_sec - 6'd1;
            if (dec[1]) s_min <= (s_min == 6'd0) ? 6'd59 : s_min - 6'd1;
            if (dec[2]) s_hour <= (s_hour == 5'd0) ? 5'(hmax) : s_hour - 5'd1;
            if (dec[3]) s_day <= (s_day == 5'd1) ? 5'(dmax) : s_day - 5'd1;
            if (dec[4]) s_month <= (s_month == 4'd1) ? 4'd12 : s_month - 4'd1;
            if (dec[5]) s_year <= s_year - 7'd1;
        end
    end

    // Capture every pulse the DUT produces, with its cycle and enable.
    always @(negedge clk) begin
        if ((inc | dec) != 6'b0) obs_q.push_back('{cyc, inc, dec, en});
    end

    task automatic load(input int se, input int mi, input int ho, input int da,
                        input int mo, input int ye);
        @(negedge clk);
        ld = 1'b1;
        ld_sec = 6'(se); ld_min = 6'(mi); ld_hour = 5'(ho);
        ld_day = 5'(da); ld_month = 4'(mo); ld_year = 7'(ye);
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while ((cyc < target) && (guard < 5000)) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic push_exp(input int c, input logic [5:0] i, input logic [5:0] d,
                            input logic [5:0] e);
        exp_q.push_back('{c, i, d, e});
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick_1hz = 1'b0; mode_set = 1'b0; field_sel = 3'd7;
        btn_up = 1'b0; btn_down = 1'b0; hour_24 = 1'b1;
        load(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (inc !== 6'h00 || dec !== 6'h00 || en !== 6'h3F || hour_num !== 5'd23
                || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_state got inc=%b dec=%b en=%b hour_num=%0d busy=%b, expected 0/0/111111/23/0",
                         inc, dec, en, hour_num, busy);
            end
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_pulses got %0d pulses, expected 0", obs_q.size());
            obs_rd = obs_q.size();
        end
    endtask

    task automatic test_rollover();
        int t;
        pulse_t e, o;
        load(59, 59, 23, 31, 12, 5);
        t = cyc + 1;
        tick_1hz = 1'b1;
        for (int k = 0; k < 6; k++) push_exp(t + k, 6'(1 << k), 6'h00, 6'h3F);
        @(negedge clk);
        tick_1hz = 1'b0;
        wait_cyc(t + 6);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rollover_busy_t6 got %b expected 1", busy);
        end
        wait_cyc(t + 7);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rollover_busy_t7 got %b expected 0", busy);
        end
        checks++;
        if (s_sec != 0 || s_min != 0 || s_hour != 0 || s_day != 1 || s_month != 1 || s_year != 6) begin
            errors++;
            $display("FAIL rollover_state got %0d:%0d:%0d d%0d m%0d y%0d expected 0:0:0 d1 m1 y6",
                     s_hour, s_min, s_sec, s_day, s_month, s_year);
        end
        // Non-wrapping tick: only the seconds pulse.
        t = cyc + 1;
        tick_1hz = 1'b1;
        push_exp(t, 6'b000001, 6'h00, 6'h3F);
        @(negedge clk);
        tick_1hz = 1'b0;
        wait_cyc(t + 1);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL single_busy_t1 got %b expected 1", busy);
        end
        wait_cyc(t + 2);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_busy_t2 got %b expected 0", busy);
        end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++;
                $display("FAIL rollover_pulse missing, expected cyc %0d inc %b", e.cyc, e.inc);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.cyc != e.cyc || o.inc !== e.inc || o.dec !== e.dec || o.en !== e.en) begin
                    errors++;
                    $display("FAIL rollover_pulse got cyc %0d inc %b dec %b en %b expected cyc %0d inc %b dec %b en %b",
                             o.cyc, o.inc, o.dec, o.en, e.cyc, e.inc, e.dec, e.en);
                end
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL rollover_extra got %0d extra pulses expected 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
    endtask

    task automatic test_day_num();
        int mo[5] = '{2, 2, 2, 4, 0};
        int ye[5] = '{24, 25, 100, 25, 25};
        int ex[5] = '{29, 28, 28, 30, 31};
        for (int i = 0; i < 5; i++) begin
            load(0, 0, 0, 1, mo[i], ye[i]);
            checks++;
            if (int'(day_num) != ex[i]) begin
                errors++;
                $display("FAIL day_num m%0d y%0d got %0d expected %0d", mo[i], ye[i], day_num, ex[i]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_edit_clamp();
        int c;
        pulse_t e, o;
        load(0, 0, 10, 31, 1, 25);
        mode_set = 1'b1;
        field_sel = 3'd4;
        repeat (2) @(negedge clk);
        checks++;
        if (en !== 6'b010000) begin
            errors++; $display("FAIL edit_en got %b expected 010000", en);
        end
        c = cyc;
        btn_up = 1'b1;
        push_exp(c + 1, 6'b010000, 6'h00, 6'b010000);
        for (int i = 0; i < 3; i++) push_exp(c + 3 + 2 * i, 6'h00, 6'b001000, 6'b001000);
        @(negedge clk);
        btn_up = 1'b0;
        wait_cyc(c + 8);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL edit_busy_c8 got %b expected 1", busy);
        end
        wait_cyc(c + 9);
        checks++;
        if (busy !== 1'b0 || s_day != 5'd28 || s_month != 4'd2) begin
            errors++;
            $display("FAIL edit_final got busy=%b day=%0d month=%0d expected 0/28/2", busy, s_day, s_month);
        end
        mode_set = 1'b0;
        field_sel = 3'd7;
        repeat (2) @(negedge clk);
        checks++;
        if (en !== 6'h3F) begin
            errors++; $display("FAIL edit_exit_en got %b expected 111111", en);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++;
                $display("FAIL edit_pulse missing, expected cyc %0d inc %b dec %b", e.cyc, e.inc, e.dec);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.cyc != e.cyc || o.inc !== e.inc || o.dec !== e.dec || o.en !== e.en) begin
                    errors++;
                    $display("FAIL edit_pulse got cyc %0d inc %b dec %b en %b expected cyc %0d inc %b dec %b en %b",
                             o.cyc, o.inc, o.dec, o.en, e.cyc, e.inc, e.dec, e.en);
                end
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL edit_extra got %0d extra pulses expected 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
    endtask

    task automatic test_hour_clamp();
        int c;
        pulse_t e, o;
        load(0, 0, 17, 1, 1, 25);
        c = cyc;
        hour_24 = 1'b0;
        for (int i = 0; i < 6; i++) push_exp(c + 3 + 2 * i, 6'h00, 6'b000100, 6'b000100);
        wait_cyc(c + 1);
        checks++;
        if (hour_num !== 5'd11) begin
            errors++; $display("FAIL hour_num_12 got %0d expected 11", hour_num);
        end
        wait_cyc(c + 15);
        checks++;
        if (busy !== 1'b0 || s_hour != 5'd11) begin
            errors++;
            $display("FAIL hour_clamp_final got busy=%b hour=%0d expected 0/11", busy, s_hour);
        end
        c = cyc;
        hour_24 = 1'b1;
        wait_cyc(c + 1);
        checks++;
        if (hour_num !== 5'd23) begin
            errors++; $display("FAIL hour_num_24 got %0d expected 23", hour_num);
        end
        wait_cyc(c + 6);
        checks++;
        if (busy !== 1'b0 || s_hour != 5'd11) begin
            errors++;
            $display("FAIL hour_24_final got busy=%b hour=%0d expected 0/11", busy, s_hour);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++;
                $display("FAIL hour_pulse missing, expected cyc %0d dec %b", e.cyc, e.dec);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.cyc != e.cyc || o.inc !== e.inc || o.dec !== e.dec || o.en !== e.en) begin
                    errors++;
                    $display("FAIL hour_pulse got cyc %0d inc %b dec %b en %b expected cyc %0d inc %b dec %b en %b",
                             o.cyc, o.inc, o.dec, o.en, e.cyc, e.inc, e.dec, e.en);
                end
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL hour_extra got %0d extra pulses expected 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
    endtask

    task automatic test_back_to_back();
        int t;
        pulse_t e, o;
        load(59, 59, 23, 31, 12, 5);
        t = cyc + 1;
        tick_1hz = 1'b1;
        for (int k = 0; k < 6; k++) push_exp(t + k, 6'(1 << k), 6'h00, 6'h3F);
        push_exp(t + 8, 6'b000001, 6'h00, 6'h3F);
        @(negedge clk);
        tick_1hz = 1'b0;
        wait_cyc(t + 1);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        wait_cyc(t + 3);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        wait_cyc(t + 7);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_busy_gap got %b expected 0", busy);
        end
        wait_cyc(t + 12);
        checks++;
        if (busy !== 1'b0 || s_sec != 6'd1) begin
            errors++;
            $display("FAIL b2b_final got busy=%b sec=%0d expected 0/1", busy, s_sec);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++;
                $display("FAIL b2b_pulse missing, expected cyc %0d inc %b", e.cyc, e.inc);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.cyc != e.cyc || o.inc !== e.inc || o.dec !== e.dec || o.en !== e.en) begin
                    errors++;
                    $display("FAIL b2b_pulse got cyc %0d inc %b dec %b en %b expected cyc %0d inc %b dec %b en %b",
                             o.cyc, o.inc, o.dec, o.en, e.cyc, e.inc, e.dec, e.en);
                end
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL b2b_extra got %0d extra pulses expected 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
    endtask

    task automatic test_reset_mid();
        int t;
        pulse_t e, o;
        load(59, 59, 23, 31, 12, 5);
        t = cyc + 1;
        tick_1hz = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(t + k, 6'(1 << k), 6'h00, 6'h3F);
        @(negedge clk);
        tick_1hz = 1'b0;
        wait_cyc(t + 2);
        checks++;
        if (inc !== 6'b000100) begin
            errors++; $display("FAIL midreset_pre_inc got %b expected 000100", inc);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (inc !== 6'h00 || dec !== 6'h00 || en !== 6'h3F || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got inc=%b dec=%b en=%b busy=%b expected 0/0/111111/0",
                     inc, dec, en, busy);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (s_hour != 5'd23 || s_min != 6'd0 || s_sec != 6'd0) begin
            errors++;
            $display("FAIL midreset_state got %0d:%0d:%0d expected 23:0:0", s_hour, s_min, s_sec);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++;
                $display("FAIL midreset_pulse missing, expected cyc %0d inc %b", e.cyc, e.inc);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.cyc != e.cyc || o.inc !== e.inc || o.dec !== e.dec || o.en !== e.en) begin
                    errors++;
                    $display("FAIL midreset_pulse got cyc %0d inc %b dec %b en %b expected cyc %0d inc %b dec %b en %b",
                             o.cyc, o.inc, o.dec, o.en, e.cyc, e.inc, e.dec, e.en);
                end
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL midreset_extra got %0d extra pulses expected 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_day_num();
        test_edit_clamp();
        test_hour_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
